// File: rtl/bcd_to_bin_seq_pkg.sv
// rtl/bcd_to_bin_seq_pkg.sv - shared state codes and digit-adjust constants for the BCD-to-binary converter
package bcd_to_bin_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_FIN   = 2'd2
   } state_t;

   localparam logic [3:0] BCD_MAX    = 4'd9;
   localparam logic [3:0] ADJ_THRESH = 4'd8;
   localparam logic [3:0] ADJ_SUB    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - reverse double-dabble digit correction plus non-decimal digit detect
module bcd_digit_adj
   import bcd_to_bin_seq_pkg::*;
(
   input  logic [3:0] din,
   output logic [3:0] dout,
   output logic       invalid
);

   assign dout    = (din >= ADJ_THRESH) ? (din - ADJ_SUB) : din;
   assign invalid = (din > BCD_MAX);

endmodule

// File: rtl/bcd_to_bin_seq.sv
// rtl/bcd_to_bin_seq.sv - sequential BCD-to-binary converter, one reverse double-dabble shift per clock
module bcd_to_bin_seq
   import bcd_to_bin_seq_pkg::*;
#(
   parameter  int DIGITS = 2,
   localparam int BW     = $clog2(10**DIGITS),
   localparam int CW     = $clog2(BW+1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [4*DIGITS-1:0] bcd_in,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [BW-1:0]       bin_out
);

   state_t              state, state_nxt;
   logic [4*DIGITS-1:0] bcd_r, bcd_shr, adj_in, adj_out;
   logic [DIGITS-1:0]   dig_bad;
   logic                any_bad;
   logic [BW-1:0]       bin_r, bin_nxt;
   logic [CW-1:0]       cnt;
   logic                last_shift;

   // The adjusters validate the capture word in IDLE and correct the shifted digits in SHIFT.
   assign adj_in     = (state == ST_IDLE) ? bcd_in : bcd_shr;
   assign bcd_shr    = bcd_r >> 1;
   assign bin_nxt    = {bcd_r[0], bin_r[BW-1:1]};
   assign last_shift = (cnt == CW'(BW-1));
   assign any_bad    = |dig_bad;

   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      bcd_digit_adj u_adj (
         .din     (adj_in[4*i +: 4]),
         .dout    (adj_out[4*i +: 4]),
         .invalid (dig_bad[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = any_bad ? ST_FIN : ST_SHIFT;
         ST_SHIFT: if (last_shift) state_nxt = ST_FIN;
         ST_FIN:   state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state != ST_IDLE);
   end

   // Result registers load on the edge that enters FIN, so done coincides with the FIN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_r   <= '0;
         bin_r   <= '0;
         cnt     <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
         bin_out <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  bcd_r <= bcd_in;
                  bin_r <= '0;
                  cnt   <= '0;
                  if (any_bad) begin
                     done    <= 1'b1;
                     err     <= 1'b1;
                     bin_out <= '0;
                  end
               end
            end
            ST_SHIFT: begin
               bcd_r <= adj_out;
               bin_r <= bin_nxt;
               cnt   <= cnt + CW'(1);
               if (last_shift) begin
                  done    <= 1'b1;
                  err     <= 1'b0;
                  bin_out <= bin_nxt;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb/tb_bcd_to_bin_seq.sv - randomized self-checking bench for bcd_to_bin_seq (2- and 3-digit instances)
module tb_bcd_to_bin_seq;

   logic        clk = 1'b0;
   logic        rst_n, start, busy, done, err;
   logic [7:0]  bcd_in;
   logic [6:0]  bin_out;
   logic        start3, busy3, done3, err3;
   logic [11:0] bcd3;
   logic [9:0]  bin3;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bcd_to_bin_seq #(.DIGITS(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
      .busy(busy), .done(done), .err(err), .bin_out(bin_out)
   );

   bcd_to_bin_seq #(.DIGITS(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .bcd_in(bcd3),
      .busy(busy3), .done(done3), .err(err3), .bin_out(bin3)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Decimal value of a packed BCD word; any non-decimal digit makes it an error with value 0.
   task automatic model(input logic [15:0] code, input int nd, output int v, output int e);
      int d;
      int w;
      v = 0;
      e = 0;
      w = 1;
      for (int i = 0; i < nd; i++) begin
         d = int'((code >> (4*i)) & 16'hF);
         if (d > 9) e = 1;
         v += d * w;
         w *= 10;
      end
      if (e != 0) v = 0;
   endtask

   function automatic logic cur_done(input int nd);
      return (nd == 2) ? done : done3;
   endfunction

   task automatic conv(input int nd, input logic [15:0] code, input string tag);
      int v, e, n, lat;
      model(code, nd, v, e);
      lat = (e != 0) ? 0 : ((nd == 2) ? 7 : 10);
      @(negedge clk);
      if (nd == 2) begin start = 1'b1; bcd_in = code[7:0]; end
      else begin start3 = 1'b1; bcd3 = code[11:0]; end
      @(negedge clk);
      if (nd == 2) begin start = 1'b0; bcd_in = 8'($urandom); end
      else begin start3 = 1'b0; bcd3 = 12'($urandom); end
      n = 0;
      while (!cur_done(nd) && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_latency"}, n, lat);
      chk({tag, "_bin"}, (nd == 2) ? 10'(bin_out) : bin3, v);
      chk({tag, "_err"}, (nd == 2) ? err : err3, e);
      chk({tag, "_busy_fin"}, (nd == 2) ? busy : busy3, 1);
      @(negedge clk);
      chk({tag, "_done_pulse"}, cur_done(nd), 0);
      chk({tag, "_busy_idle"}, (nd == 2) ? busy : busy3, 0);
      chk({tag, "_bin_held"}, (nd == 2) ? 10'(bin_out) : bin3, v);
   endtask

   initial begin
      int dones, n;
      logic [15:0] code;
      rst_n = 1'b0; start = 1'b0; start3 = 1'b0; bcd_in = '0; bcd3 = '0;
      repeat (2) @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_err", err, 0);
      chk("reset_bin", bin_out, 0);
      chk("reset_bin3", bin3, 0);
      rst_n = 1'b1;

      conv(2, 16'h99, "first_99");

      for (int t = 0; t <= 9; t++)
         for (int o = 0; o <= 9; o++)
            conv(2, 16'((t << 4) | o), "sweep");

      conv(2, 16'h3A, "err_3A");
      conv(2, 16'h12, "after_err_12");

      // Extra starts during SHIFT and during FIN must not produce a second conversion.
      @(negedge clk); start = 1'b1; bcd_in = 8'h45;
      @(negedge clk); start = 1'b0; bcd_in = 8'h77;
      dones = 0;
      for (int c = 0; c < 20; c++) begin
         if (done) begin
            dones++;
            chk("ignore_bin", bin_out, 45);
         end
         start = (c == 2 || c == 5 || done) ? 1'b1 : 1'b0;
         @(negedge clk);
      end
      start = 1'b0;
      chk("ignore_one_done", dones, 1);

      // Asynchronous reset three clocks into a conversion.
      @(negedge clk); start = 1'b1; bcd_in = 8'h99;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_err", err, 0);
      chk("abort_bin", bin_out, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (done) dones++;
      end
      chk("abort_no_done", dones, 0);
      conv(2, 16'h50, "after_abort_50");

      for (int r = 0; r < 60; r++) begin
         code = 16'({$urandom_range(0, 15), 4'h0}) | 16'($urandom_range(0, 15));
         conv(2, code, "rand2");
      end

      conv(3, 16'h999, "d3_999");
      conv(3, 16'h000, "d3_000");
      for (int r = 0; r < 20; r++) begin
         code = '0;
         for (int d = 0; d < 3; d++) begin
            n = (r % 3 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
            code = code | 16'(n << (4*d));
         end
         conv(3, code, "rand3");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
